// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared definitions for the direct-mapped cache.
//   state_t : controller states
//
// state  | meaning
// IDLE   | accept a CPU access or a flush; read hits complete here
// FILL   | read miss, waiting for backing memory to return the word
// WRITE  | write-through in flight, waiting for backing memory to accept it
package dm_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/dm_cache_sat_cnt.sv
// dm_cache_sat_cnt: W-bit event counter that sticks at all-ones.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current count
module dm_cache_sat_cnt
    import dm_cache_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, one word per line, write-through / no-write-allocate.
//   CLK, RST                   : clock, asynchronous active-high reset
//   Req, WE, Address, Data_In  : CPU access, held stable until Ready
//   Data_Out, Ready            : CPU response (zero-wait on read hit)
//   Flush                      : invalidate all lines (honoured in IDLE only)
//   Mem_Req/WE/Addr/WData      : backing-memory request, held until Mem_Ack
//   Mem_RData, Mem_Ack         : backing-memory response
//   Hit_Count, Miss_Count      : saturating access statistics
module dm_cache
    import dm_cache_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int AW    = 32,
    parameter int LINES = 64,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Req,
    input  logic             WE,
    input  logic [AW-1:0]    Address,
    input  logic [SIZE-1:0]  Data_In,
    output logic [SIZE-1:0]  Data_Out,
    output logic             Ready,
    input  logic             Flush,
    output logic             Mem_Req,
    output logic             Mem_WE,
    output logic [AW-1:0]    Mem_Addr,
    output logic [SIZE-1:0]  Mem_WData,
    input  logic [SIZE-1:0]  Mem_RData,
    input  logic             Mem_Ack,
    output logic [CNT_W-1:0] Hit_Count,
    output logic [CNT_W-1:0] Miss_Count
);

    localparam int IW = $clog2(LINES);
    localparam int TW = AW - IW;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_mem  [LINES];
    logic [SIZE-1:0]   data_mem [LINES];

    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag;
    logic              hit;
    logic              idle_acc;
    logic              fill_done;
    logic              wr_hit;

    assign idx       = Address[IW-1:0];
    assign tag       = Address[AW-1:IW];
    assign hit       = valid[idx] && (tag_mem[idx] == tag);
    // A flush in IDLE pre-empts the access; it is served on the next cycle.
    assign idle_acc  = (state == IDLE) && Req && !Flush;
    assign fill_done = (state == FILL) && Mem_Ack;
    assign wr_hit    = idle_acc && WE && hit;

    // Address and write data are held by the CPU, so the memory side can
    // reflect them directly while the registered request is up.
    assign Mem_Addr  = Mem_Req ? Address : '0;
    assign Mem_WData = Mem_WE  ? Data_In : '0;

    always_comb begin
        Ready    = 1'b0;
        Data_Out = '0;
        case (state)
            IDLE: begin
                if (idle_acc && !WE && hit) begin
                    Ready    = 1'b1;
                    Data_Out = data_mem[idx];
                end
            end
            FILL: begin
                if (Mem_Ack) begin
                    Ready    = 1'b1;
                    Data_Out = Mem_RData;
                end
            end
            WRITE: begin
                if (Mem_Ack) Ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            valid   <= '0;
            Mem_Req <= 1'b0;
            Mem_WE  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Flush) begin
                        valid <= '0;
                    end else if (Req) begin
                        if (WE) begin
                            state   <= WRITE;
                            Mem_Req <= 1'b1;
                            Mem_WE  <= 1'b1;
                        end else if (!hit) begin
                            state   <= FILL;
                            Mem_Req <= 1'b1;
                            Mem_WE  <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (Mem_Ack) begin
                        valid[idx] <= 1'b1;
                        state      <= IDLE;
                        Mem_Req    <= 1'b0;
                    end
                end
                WRITE: begin
                    if (Mem_Ack) begin
                        state   <= IDLE;
                        Mem_Req <= 1'b0;
                        Mem_WE  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Mem_Req <= 1'b0;
                    Mem_WE  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data storage carries no reset; the valid bits guard it.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= Mem_RData;
        end else if (wr_hit) begin
            data_mem[idx] <= Data_In;
        end
    end

    dm_cache_sat_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (idle_acc && hit),
        .count (Hit_Count)
    );

    dm_cache_sat_cnt #(.W(CNT_W)) u_miss_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (idle_acc && !hit),
        .count (Miss_Count)
    );

endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, meaning data word width.
REQ-002 The block SHALL have parameter AW, default 32, meaning word-address width.
REQ-003 The block SHALL have parameter LINES, default 64, meaning number of one-word lines; a power of two, at least 2.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-005 The block SHALL have port CLK  in  1  sole clock; all state updates on posedge.
REQ-006 The block SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port Req  in  1  CPU access valid.
REQ-008 The block SHALL have port WE  in  1  CPU access is a write.
REQ-009 The block SHALL have port Address  in  AW  CPU word address.
REQ-010 The block SHALL have port Data_In  in  SIZE  CPU write data.
REQ-011 The block SHALL have port Data_Out  out  SIZE  CPU read data.
REQ-012 The block SHALL have port Ready  out  1  CPU access completes this cycle.
REQ-013 The block SHALL have port Flush  in  1  invalidate all lines.
REQ-014 The block SHALL have ports Mem_Req out 1, Mem_WE out 1, Mem_Addr out AW and Mem_WData out SIZE, meaning the backing-memory request.
REQ-015 The block SHALL have ports Mem_RData in SIZE and Mem_Ack in 1, meaning the backing-memory response.
REQ-016 The block SHALL have ports Hit_Count out CNT_W and Miss_Count out CNT_W, meaning statistics.

Function
REQ-017 The block SHALL be direct-mapped: index = Address[log2(LINES)-1:0], tag = the remaining upper bits; each line holds a valid bit, tag and data.
REQ-018 The FSM SHALL have three states: IDLE, FILL and WRITE.
REQ-019 IDLE read hit (Req, !WE, valid, tag match): Ready=1 and Data_Out=line data in the same cycle (combinational, zero wait); no Mem_Req; Hit_Count+1.
REQ-020 IDLE read miss: Ready=0; go to FILL; Miss_Count+1.
REQ-021 In FILL, Mem_Req=1, Mem_WE=0, Mem_Addr=Address until Mem_Ack.
REQ-022 On the FILL Mem_Ack cycle: line written valid with tag and Mem_RData; Data_Out=Mem_RData; Ready=1; return to IDLE.
REQ-023 IDLE write: go to WRITE; Hit_Count+1 on hit, Miss_Count+1 on miss.
REQ-024 Write hit: line data updated with Data_In on entry (write-through). Write miss: no allocation, cache arrays unchanged.
REQ-025 In WRITE, Mem_Req=1, Mem_WE=1, Mem_Addr=Address and Mem_WData=Data_In until Mem_Ack; on the Mem_Ack cycle Ready=1 and return to IDLE.
REQ-026 The CPU SHALL hold Req, WE, Address and Data_In stable until Ready; Mem_Req, once raised, SHALL stay high with stable outputs until Mem_Ack.
REQ-027 Mem_Ack in IDLE SHALL be ignored.
REQ-028 Mem_Ack can arrive in the first FILL/WRITE cycle, giving a minimum miss/write latency of 1 wait cycle.
REQ-029 Flush SHALL be sampled only in IDLE; it clears all valid bits in one cycle and takes priority over a simultaneous Req. That cycle has Ready=0 and no counter change, and the Req is served next cycle.
REQ-030 Flush in FILL/WRITE SHALL be ignored.
REQ-031 Data_Out SHALL be 0 whenever Ready=0 or the access is a write.
REQ-032 Counters SHALL saturate at all-ones and never wrap.

Reset
REQ-033 RST SHALL force, asynchronously: state=IDLE, all valid=0, Hit_Count=0, Miss_Count=0, Mem_Req=0, Mem_WE=0, Ready=0.
REQ-034 Tag and data arrays SHALL not be reset.
REQ-035 RST mid-FILL or mid-WRITE SHALL abandon the transaction; any pending Mem_Ack after release is ignored.

Structure
REQ-036 State encodings SHALL live in shared package dm_cache_pkg.
REQ-037 One sub-module, dm_cache_sat_cnt (CNT_W-bit saturating counter with async reset), SHALL be instantiated twice.

Verification (LINES=64)
REQ-038 After reset, mem[0x10]=0xAA55, read 0x10, Ack after 3 cycles -> Ready only on the Ack cycle with Data_Out=0xAA55 and Miss=1; repeat read -> Ready same cycle, no Mem_Req, Hit=1.
REQ-039 Read 0x10, 0x50, 0x10 (same index 16) -> three misses, three fills.
REQ-040 Write 0x10=0x1234 after a fill -> Mem_WE=1 with data 0x1234, line updated; read 0x10 hits and returns 0x1234. Write miss 0x20, then read 0x20 -> miss.
REQ-041 Flush and Req(read 0x10, cached) in the same cycle -> Ready=0 that cycle; next cycle miss.
REQ-042 RST pulse mid-FILL -> Mem_Req drops without a clock edge, counters=0; after release, read 0x10 misses.
REQ-043 CNT_W=4, 20 read hits -> Hit_Count=15.
